etroc_tx_emulator: RTL and testbench
====================================

# etroc_tx_emulator

Emulates the ETROC2 serial output at the far end of the link that the test firmware's receive path samples, descrambles and multiplexes. On each trigger it builds a 40-bit frame stream: filler, then header, data and trailer. It optionally scrambles that stream with the self-synchronizing scrambler that the receive-side descrambler inverts. A gearbox turns the 40-bit frames into 8, 16 or 32 bits per clk40 for the GTX TX data port, which gives the board a closed-loop source for link bring-up and descrambler verification.

## Interface
Parameters:
- FIFO_DEPTH, 4: L1A queue depth in entries; must be a power of two.
- BCID_MAX, 3563: last BCID value before wrap to 0.

Ports:
- clk40  input  1: sole clock, 40 MHz.
- reset  input  1: asynchronous, active-high.
- enable  input  1: when 1, the frame FSM and the gearbox advance; when 0, dout is held at 0.
- rate  input  2: 0 gives 8 bits/cycle (320 Mb/s), 1 gives 16 bits/cycle (640 Mb/s), 2 and 3 give 32 bits/cycle (1.28 Gb/s).
- polarity  input  1: when 1, the valid dout bits are inverted.
- scr_bypass  input  1: when 1, frames pass through unscrambled.
- l1a  input  1: trigger pulse, one cycle wide.
- hit_num  input  4: number of data frames for this trigger, sampled together with l1a.
- dout  output  32: TX word; dout[0] is sent first; bits at and above the active width are 0.
- fifo_full  output  1: the L1A queue is full.
- busy  output  1: the FSM is not in FILLER.
- l1a_drop_cnt  output  16: count of dropped triggers, saturating.

## Operation
- BCID counter (12 bit):
  - counts 0..BCID_MAX, then wraps to 0;
  - increments every cycle regardless of enable.
- L1A queue:
  - l1a=1 and queue not full: push {bcid, hit_num};
  - l1a=1 and queue full: drop the trigger and increment l1a_drop_cnt;
  - push happens regardless of enable.
- Frame FSM (states FILLER, HEADER, DATA, TRAILER):
  - the FSM advances only on a frame pull;
  - FILLER: if the queue is non-empty, pop and go to HEADER; otherwise emit a filler frame;
  - HEADER goes to DATA when hit_num>0, otherwise to TRAILER;
  - DATA emits hit_num frames, hit_idx 0..hit_num-1, then goes to TRAILER;
  - TRAILER increments l1a_cnt (8 bit, wraps) and goes to FILLER.
- Frame formats (bit 39 first in the list):
  - filler: {16'h3C5C, 2'b10, 22'h0}.
  - header: {16'h3C5C, 2'b00, 8'hE2, bcid_q[11:0], 2'b01}.
  - data: {1'b1, 3'b000, hit_idx[3:0], l1a_cnt[7:0], bcid_q[11:0], 12'hA5A}.
  - trailer: {2'b01, 6'h0, hit_num_q[7:0] zero-extended, l1a_cnt[7:0], chk[7:0], 8'h00}.
- Checksum chk: XOR of all 5 bytes of every data frame in the event; 8'h00 when hit_num=0.
- Scrambler:
  - self-synchronizing, polynomial x^58+x^39+1, 40-bit parallel;
  - frame bit 0 is the oldest bit;
  - 58-bit state, updated only on a frame pull;
  - scr_bypass=1: frames pass unchanged and the state is still updated with the raw bits.
- Gearbox:
  - 80-bit buffer with bit count cnt;
  - on each enabled cycle with width w: if cnt<w, pull one frame and append it above the cnt valid bits;
  - then output the w lowest bits and set cnt = cnt + 40·pull - w;
  - invariant: cnt ≤ 71 after load.
- Rate change while enabled:
  - cnt is cleared to 0 and any partially sent frame bits are discarded;
  - the FSM state is kept.
- enable=0:
  - FSM, gearbox and scrambler hold their state; dout=0.

## Timing
- Reset values:
  - dout=0, fifo_full=0, busy=0, l1a_drop_cnt=0;
  - bcid=0, l1a_cnt=0, cnt=0, scrambler state=0, FSM=FILLER, queue empty.
- dout is registered: bits pulled in cycle t appear at dout at edge t+1, behind any residual bits from earlier frames.
- Trigger to queue: l1a at edge t means the queue is non-empty at t+1.
- Queue to FSM: the earliest HEADER pull is the first pull at or after t+1.
- The queue frees its slot on the pop in FILLER.
- A simultaneous push and pop with the queue full is accepted and nothing is dropped.
- l1a_drop_cnt holds at 16'hFFFF.
- Reset asserted mid-event abandons the event immediately.

## Configuration
- TX_SCRAMBLER_EN defined: the scrambler is instantiated and scr_bypass works as described.
- TX_SCRAMBLER_EN undefined: no scrambler logic is built; frames are always sent raw and scr_bypass is ignored.

## Test plan
- Filler stream: reset, enable=1, rate=2, scr_bypass=1, no l1a → dout = 32'h5C800000 on the first cycle, and the 40-bit filler 40'h3C5C800000 repeats seamlessly.
- Event frames: rate=0, scr_bypass=1, one l1a with hit_num=2 → 8-bit lanes carry header, data idx0, data idx1 and trailer, in that order. The trailer has hit_num=0x02, the correct chk, and l1a_cnt=0. Upper dout bits are 0.
- Queue overflow: enable=0, six l1a pulses → fifo_full=1 and l1a_drop_cnt=2. Then enable=1 → exactly 4 events are sent, and fifo_full drops after the first pop.
- Scrambler round-trip: scr_bypass=0, 20 random events at rate=1, dout fed to the receive-side descrambler → after the 58-bit sync period, frames match the bypassed reference bit-exactly.
- Polarity and rate change: toggle polarity → valid bits invert. Change rate 2→0 mid-event → cnt is cleared and the next output is 8-bit aligned.
- Reset mid-event: assert reset during DATA → all outputs return to reset values, and the next frames are filler with bcid starting at 0.

Source files
------------

// File: rtl/etroc_tx_emulator.sv
// ETROC2 serial TX emulator: trigger queue, frame FSM, gearbox.
// Optional scrambler is built only when TX_SCRAMBLER_EN is defined.
//
// Ports:
//   clk40        in   sole clock
//   reset        in   async, active-high
//   enable       in   advance FSM/gearbox; dout forced to 0 when low
//   rate[1:0]    in   0: 8b, 1: 16b, 2/3: 32b per cycle
//   polarity     in   invert the valid dout bits
//   scr_bypass   in   send frames raw (scrambler still tracks them)
//   l1a          in   trigger pulse
//   hit_num[3:0] in   data frames for this trigger
//   dout[31:0]   out  TX word, bit 0 first, unused upper bits 0
//   fifo_full    out  trigger queue full
//   busy         out  event in progress
//   l1a_drop_cnt out  dropped triggers, saturating
module etroc_tx_emulator #(
    parameter int FIFO_DEPTH = 4,
    parameter int BCID_MAX   = 3563
) (
    input  logic        clk40,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  rate,
    input  logic        polarity,
    input  logic        scr_bypass,
    input  logic        l1a,
    input  logic [3:0]  hit_num,
    output logic [31:0] dout,
    output logic        fifo_full,
    output logic        busy,
    output logic [15:0] l1a_drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_FILLER  = 2'd0;
    localparam logic [1:0] ST_HEADER  = 2'd1;
    localparam logic [1:0] ST_DATA    = 2'd2;
    localparam logic [1:0] ST_TRAILER = 2'd3;

    localparam logic [39:0] FILLER_FRAME = {16'h3C5C, 2'b10, 22'h0};

    logic [11:0] bcid;
    logic [15:0] q_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        q_empty, push, pop, drop;
    logic [15:0] head;
    logic [1:0]  state, emit;
    logic [3:0]  hit_idx, hit_num_q;
    logic [11:0] bcid_q;
    logic [7:0]  l1a_cnt, chk, data_xor;
    logic [39:0] data_frame, frame, tx_frame;
    logic [5:0]  width, width_q;
    logic [31:0] mask;
    logic        rate_chg, pull;
    logic [6:0]  gb_cnt, cnt_eff;
    logic [79:0] gb_buf, merged;

    always_comb begin
        width = 6'd32;
        mask  = 32'hFFFF_FFFF;
        case (rate)
            2'd0: begin
                width = 6'd8;
                mask  = 32'h0000_00FF;
            end
            2'd1: begin
                width = 6'd16;
                mask  = 32'h0000_FFFF;
            end
            default: ;
        endcase
    end

    assign q_empty   = wr_ptr == rd_ptr;
    assign fifo_full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign head      = q_mem[rd_ptr[AW-1:0]];
    assign busy      = state != ST_FILLER;

    // A pull in FILLER with a queued trigger emits the header
    // straight away, so HEADER never needs a register cycle.
    assign emit = (state == ST_FILLER && !q_empty) ? ST_HEADER : state;

    assign rate_chg = width != width_q;
    assign cnt_eff  = rate_chg ? 7'd0 : gb_cnt;
    assign pull     = enable && (cnt_eff < {1'b0, width});
    assign pop      = pull && emit == ST_HEADER;
    assign push     = l1a && (!fifo_full || pop);
    assign drop     = l1a && fifo_full && !pop;

    assign data_frame = {1'b1, 3'b000, hit_idx, l1a_cnt,
                         bcid_q, 12'hA5A};
    assign data_xor = data_frame[39:32] ^ data_frame[31:24]
                    ^ data_frame[23:16] ^ data_frame[15:8]
                    ^ data_frame[7:0];

    always_comb begin
        frame = FILLER_FRAME;
        unique case (emit)
            ST_HEADER:
                frame = {16'h3C5C, 2'b00, 8'hE2, head[15:4], 2'b01};
            ST_DATA:
                frame = data_frame;
            ST_TRAILER:
                frame = {2'b01, 6'h0, 4'h0, hit_num_q,
                         l1a_cnt, chk, 8'h00};
            ST_FILLER:
                frame = FILLER_FRAME;
        endcase
    end

`ifdef TX_SCRAMBLER_EN
    logic [57:0] scr_state, scr_next;
    logic [39:0] scr_out;

    // scr_state[57] is the newest bit; ext[58+i] is frame bit i.
    always_comb begin
        logic [97:0] ext;
        ext = {40'd0, scr_state};
        for (int i = 0; i < 40; i++) begin
            ext[58+i] = frame[i] ^ ext[i+19] ^ ext[i];
        end
        scr_out  = ext[97:58];
        scr_next = scr_bypass ? {frame, scr_state[57:40]}
                              : ext[97:40];
    end

    assign tx_frame = scr_bypass ? frame : scr_out;

    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) scr_state <= '0;
        else if (pull) scr_state <= scr_next;
    end
`else
    logic scr_unused;
    assign scr_unused = scr_bypass;
    assign tx_frame   = frame;
`endif

    // New frame lands directly above the residual bits.
    assign merged = (rate_chg ? 80'd0 : gb_buf)
                  | (pull ? ({40'd0, tx_frame} << cnt_eff) : 80'd0);

    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) bcid <= '0;
        else if (bcid == 12'(BCID_MAX)) bcid <= '0;
        else bcid <= bcid + 12'd1;
    end

    always_ff @(posedge clk40) begin
        if (push) q_mem[wr_ptr[AW-1:0]] <= {bcid, hit_num};
    end

    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            l1a_drop_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (drop && l1a_drop_cnt != 16'hFFFF)
                l1a_drop_cnt <= l1a_drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            state     <= ST_FILLER;
            hit_idx   <= '0;
            hit_num_q <= '0;
            bcid_q    <= '0;
            l1a_cnt   <= '0;
            chk       <= '0;
        end else if (pull) begin
            unique case (emit)
                ST_HEADER: begin
                    bcid_q    <= head[15:4];
                    hit_num_q <= head[3:0];
                    hit_idx   <= '0;
                    chk       <= '0;
                    state <= (head[3:0] != 4'd0) ? ST_DATA
                                                 : ST_TRAILER;
                end
                ST_DATA: begin
                    chk     <= chk ^ data_xor;
                    hit_idx <= hit_idx + 4'd1;
                    if (hit_idx == hit_num_q - 4'd1)
                        state <= ST_TRAILER;
                end
                ST_TRAILER: begin
                    l1a_cnt <= l1a_cnt + 8'd1;
                    state   <= ST_FILLER;
                end
                ST_FILLER: ;
            endcase
        end
    end

    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            dout    <= '0;
            gb_buf  <= '0;
            gb_cnt  <= '0;
            width_q <= 6'd8;
        end else begin
            width_q <= width;
            if (enable) begin
                dout   <= (merged[31:0] ^ {32{polarity}}) & mask;
                gb_buf <= merged >> width;
                gb_cnt <= cnt_eff + (pull ? 7'd40 : 7'd0)
                        - {1'b0, width};
            end else begin
                dout <= '0;
            end
        end
    end

endmodule

// File: tb/tb_etroc_tx_emulator.sv
// Bench for etroc_tx_emulator: fixed vectors, hand sequences,
// random traffic against a bit-queue reference model.
module tb_etroc_tx_emulator;

    localparam int DEPTH = 4;
    localparam int BMAX  = 3563;
`ifdef TX_SCRAMBLER_EN
    localparam bit SCR_BUILT = 1'b1;
`else
    localparam bit SCR_BUILT = 1'b0;
`endif

    logic        clk40 = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  rate = 2'd2;
    logic        polarity = 1'b0;
    logic        scr_bypass = 1'b1;
    logic        l1a = 1'b0;
    logic [3:0]  hit_num = 4'd0;
    logic [31:0] dout;
    logic        fifo_full;
    logic        busy;
    logic [15:0] l1a_drop_cnt;

    etroc_tx_emulator #(
        .FIFO_DEPTH(DEPTH),
        .BCID_MAX(BMAX)
    ) dut (
        .clk40(clk40),
        .reset(reset),
        .enable(enable),
        .rate(rate),
        .polarity(polarity),
        .scr_bypass(scr_bypass),
        .l1a(l1a),
        .hit_num(hit_num),
        .dout(dout),
        .fifo_full(fifo_full),
        .busy(busy),
        .l1a_drop_cnt(l1a_drop_cnt)
    );

    always #5 clk40 = ~clk40;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: events become frame lists, frames become a
    // serial bit stream, dout pops w bits per enabled cycle.
    typedef struct {
        logic [11:0] bcid;
        logic [3:0]  hit;
    } ev_t;

    ev_t         evq[$];
    logic [39:0] frq[$];
    bit          sbits[$];
    bit          rbits[$];
    int          m_bcid, m_l1a, m_drop, m_prev_w, cur_w;
    logic [57:0] m_h;
    logic [31:0] exp_dout, exp_raw;
    bit          dscr_on = 0;
    logic [57:0] dh;
    int          dscr_n;

    function automatic int w_of(input logic [1:0] r);
        return (r == 2'd0) ? 8 : ((r == 2'd1) ? 16 : 32);
    endfunction

    task automatic model_reset();
        m_bcid = 0; m_l1a = 0; m_drop = 0; m_prev_w = 8;
        cur_w = 8; m_h = '0;
        evq.delete(); frq.delete();
        sbits.delete(); rbits.delete();
        exp_dout = '0; exp_raw = '0;
    endtask

    task automatic build_event(input ev_t ev);
        logic [39:0] f;
        logic [7:0]  c;
        c = 8'h00;
        frq.push_back({16'h3C5C, 2'b00, 8'hE2, ev.bcid, 2'b01});
        for (int k = 0; k < int'(ev.hit); k++) begin
            f = {1'b1, 3'b000, 4'(k), 8'(m_l1a), ev.bcid, 12'hA5A};
            for (int j = 0; j < 5; j++) c ^= f[8*j +: 8];
            frq.push_back(f);
        end
        frq.push_back({2'b01, 6'h0, 4'h0, ev.hit,
                       8'(m_l1a), c, 8'h00});
        m_l1a = (m_l1a + 1) % 256;
    endtask

    task automatic next_frame(output logic [39:0] f);
        if (frq.size() == 0 && evq.size() > 0)
            build_event(evq.pop_front());
        if (frq.size() > 0) f = frq.pop_front();
        else f = 40'h3C5C800000;
    endtask

    task automatic model_cycle();
        logic [39:0] f;
        bit d, s;
        int w;
        w = w_of(rate);
        exp_dout = '0;
        exp_raw  = '0;
        if (enable) begin
            if (w != m_prev_w) begin
                sbits.delete(); rbits.delete();
            end
            if (sbits.size() < w) begin
                next_frame(f);
                for (int i = 0; i < 40; i++) begin
                    d = f[i];
                    s = (SCR_BUILT && !scr_bypass)
                        ? (d ^ m_h[38] ^ m_h[57]) : d;
                    m_h = {m_h[56:0], s};
                    sbits.push_back(s);
                    rbits.push_back(d);
                end
            end
            for (int i = 0; i < w; i++) begin
                exp_dout[i] = sbits.pop_front() ^ polarity;
                exp_raw[i]  = rbits.pop_front();
            end
            cur_w = w;
        end
        m_prev_w = w;
        if (l1a) begin
            if (evq.size() < DEPTH)
                evq.push_back('{12'(m_bcid), hit_num});
            else if (m_drop < 65535)
                m_drop++;
        end
        m_bcid = (m_bcid == BMAX) ? 0 : m_bcid + 1;
    endtask

    task automatic step();
        int bad;
        bit r, d, any;
        bit was_en;
        was_en = enable;
        model_cycle();
        @(posedge clk40);
        #1;
        check("dout", dout, exp_dout);
        check("busy", 32'(busy), 32'(frq.size() > 0));
        check("fifo_full", 32'(fifo_full), 32'(evq.size() == DEPTH));
        check("drop_cnt", 32'(l1a_drop_cnt), 32'(m_drop));
        if (SCR_BUILT && dscr_on && was_en) begin
            bad = 0;
            any = 0;
            for (int i = 0; i < cur_w; i++) begin
                r = dout[i];
                d = r ^ dh[38] ^ dh[57];
                dh = {dh[56:0], r};
                if (dscr_n >= 58) begin
                    any = 1;
                    if (d != exp_raw[i]) bad++;
                end
                dscr_n++;
            end
            if (any) check("descramble_bits", 32'(bad), 32'd0);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        check("rst_dout", dout, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_drop", 32'(l1a_drop_cnt), 32'd0);
        model_reset();
        @(posedge clk40);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  rate;
        logic        pol;
        logic [31:0] exp;
    } vec_t;

    vec_t        tab[12];
    logic [39:0] ev_exp[5];
    logic [7:0]  bytes[25];
    logic [23:0] upper;
    logic [39:0] fr;
    int          rises, k;
    bit          prev_busy;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: no finish by %0t", $time);
        $fatal(1);
    end

    initial begin
        tab[0]  = '{2'd2, 1'b0, 32'h5C80_0000};
        tab[1]  = '{2'd2, 1'b0, 32'h8000_003C};
        tab[2]  = '{2'd2, 1'b0, 32'h0000_3C5C};
        tab[3]  = '{2'd2, 1'b0, 32'h003C_5C80};
        tab[4]  = '{2'd2, 1'b0, 32'h3C5C_8000};
        tab[5]  = '{2'd2, 1'b1, 32'hA37F_FFFF};
        tab[6]  = '{2'd2, 1'b1, 32'h7FFF_FFC3};
        tab[7]  = '{2'd0, 1'b0, 32'h0000_0000};
        tab[8]  = '{2'd0, 1'b0, 32'h0000_0000};
        tab[9]  = '{2'd0, 1'b0, 32'h0000_0080};
        tab[10] = '{2'd0, 1'b0, 32'h0000_005C};
        tab[11] = '{2'd0, 1'b0, 32'h0000_003C};
        ev_exp[0] = 40'h3C5C800000;
        ev_exp[1] = 40'h3C5C388001;
        ev_exp[2] = 40'h8000000A5A;
        ev_exp[3] = 40'h8100000A5A;
        ev_exp[4] = 40'h4002000100;

        #2;
        apply_reset();

        // filler stream, polarity, rate change 32 -> 8
        enable = 1'b1;
        scr_bypass = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rate = tab[i].rate;
            polarity = tab[i].pol;
            step();
            check($sformatf("vec%0d", i), dout, tab[i].exp);
        end

        // one event, hit_num=2, byte lanes
        apply_reset();
        rate = 2'd0; polarity = 1'b0; scr_bypass = 1'b1;
        enable = 1'b1;
        upper = '0;
        l1a = 1'b1; hit_num = 4'd2;
        for (int i = 0; i < 25; i++) begin
            step();
            l1a = 1'b0;
            bytes[i] = dout[7:0];
            upper |= dout[31:8];
        end
        check("upper_bits", 32'(upper), 32'd0);
        for (int f = 0; f < 5; f++) begin
            for (int j = 0; j < 5; j++)
                fr[8*j +: 8] = bytes[5*f + j];
            check($sformatf("ev_frame%0d_lo", f), fr[31:0],
                  ev_exp[f][31:0]);
            check($sformatf("ev_frame%0d_hi", f), 32'(fr[39:32]),
                  32'(ev_exp[f][39:32]));
        end

        // queue overflow while disabled
        apply_reset();
        enable = 1'b0; rate = 2'd0;
        for (int i = 0; i < 6; i++) begin
            l1a = 1'b1; hit_num = 4'(i % 3);
            step();
            l1a = 1'b0;
            step();
        end
        check("ovf_full", 32'(fifo_full), 32'd1);
        check("ovf_drop", 32'(l1a_drop_cnt), 32'd2);
        enable = 1'b1;
        step();
        check("ovf_full_after_pop", 32'(fifo_full), 32'd0);
        check("ovf_busy_after_pop", 32'(busy), 32'd1);
        rises = 1;
        prev_busy = busy;
        for (int i = 0; i < 150; i++) begin
            step();
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
        end
        check("ovf_events", 32'(rises), 32'd4);

        // scrambler round trip at 16 bits/cycle
        apply_reset();
        enable = 1'b1; rate = 2'd1; polarity = 1'b0;
        scr_bypass = 1'b0;
        dh = '0; dscr_n = 0; dscr_on = 1;
        for (int e = 0; e < 20; e++) begin
            l1a = 1'b1;
            hit_num = 4'($urandom_range(0, 15));
            step();
            l1a = 1'b0;
            repeat ($urandom_range(4, 50)) step();
        end
        repeat (200) step();
        dscr_on = 0;

        // random traffic
        for (int i = 0; i < 800; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) rate = 2'($urandom);
            if ($urandom_range(0, 49) == 0) polarity = ~polarity;
            if ($urandom_range(0, 49) == 0)
                scr_bypass = ~scr_bypass;
            l1a = !l1a && ($urandom_range(0, 14) == 0);
            hit_num = 4'($urandom_range(0, 15));
            step();
        end
        l1a = 1'b0;

        // reset in the middle of an event
        apply_reset();
        rate = 2'd2; scr_bypass = 1'b1; polarity = 1'b0;
        enable = 1'b1;
        l1a = 1'b1; hit_num = 4'd8;
        step();
        l1a = 1'b0;
        k = 0;
        while (!busy && k < 20) begin
            step();
            k++;
        end
        check("mid_busy_seen", 32'(busy), 32'd1);
        repeat (3) step();
        apply_reset();
        enable = 1'b1; rate = 2'd2;
        l1a = 1'b1; hit_num = 4'd0;
        step();
        l1a = 1'b0;
        check("post_reset_filler", dout, 32'h5C80_0000);
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
